// File: rtl/pc_fetch_pkg.sv
// Shared fetch-stage types and reset/increment defaults used by fetch, decode and CSR blocks.
package pc_fetch_pkg;

  localparam int unsigned DEFAULT_XLEN         = 32;
  localparam logic [31:0] DEFAULT_RESET_VECTOR = 32'h0;
  localparam int unsigned DEFAULT_INCR         = 4;
  localparam int unsigned DEFAULT_ALIGN_BITS   = 2;

  typedef enum logic [1:0] {
    BOOT,
    RUN,
    HALT
  } state_e;

  typedef enum logic [1:0] {
    NONE,
    BR,
    TRAP
  } cause_e;

endpackage

// File: rtl/pc_redirect_arb.sv
// Redirect arbitration: trap-over-branch priority, target alignment, and the
// pending-redirect register that holds a redirect until the PC may change.
module pc_redirect_arb
  import pc_fetch_pkg::*;
#(
  parameter int unsigned XLEN       = DEFAULT_XLEN,
  parameter int unsigned ALIGN_BITS = DEFAULT_ALIGN_BITS
) (
  input  logic            clk,
  input  logic            reset,
  input  logic            trap_valid,
  input  logic [XLEN-1:0] trap_target,
  input  logic            br_valid,
  input  logic [XLEN-1:0] br_target,
  input  logic            capture,
  input  logic            clear,
  output logic            redir,
  output logic            misalign,
  output logic            eff_valid,
  output logic [XLEN-1:0] eff_tgt
);

  logic [XLEN-1:0] raw_tgt;
  logic [XLEN-1:0] new_tgt;
  cause_e          new_cause;
  cause_e          eff_cause;
  logic            keep_pend;
  logic            pend_valid;
  logic [XLEN-1:0] pend_tgt;
  cause_e          pend_cause;

  // Pick the winning new redirect, align it, and merge it with any pending one.
  always_comb begin
    raw_tgt   = trap_valid ? trap_target : br_target;
    new_cause = trap_valid ? TRAP : (br_valid ? BR : NONE);
    redir     = trap_valid | br_valid;
    misalign  = redir & (|raw_tgt[ALIGN_BITS-1:0]);
    new_tgt   = raw_tgt;
    new_tgt[ALIGN_BITS-1:0] = '0;
    // A pending trap is only displaced by another trap.
    keep_pend = pend_valid && (pend_cause == TRAP) && !trap_valid;
    if (redir && !keep_pend) begin
      eff_valid = 1'b1;
      eff_tgt   = new_tgt;
      eff_cause = new_cause;
    end else begin
      eff_valid = pend_valid;
      eff_tgt   = pend_tgt;
      eff_cause = pend_cause;
    end
  end

  // Pending-redirect register: loaded while the PC is locked, cleared once applied.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      pend_valid <= 1'b0;
      pend_tgt   <= '0;
      pend_cause <= NONE;
    end else if (clear) begin
      pend_valid <= 1'b0;
      pend_cause <= NONE;
    end else if (capture && redir) begin
      pend_valid <= eff_valid;
      pend_tgt   <= eff_tgt;
      pend_cause <= eff_cause;
    end
  end

endmodule

// File: rtl/pc_fetch_gen.sv
// Fetch-stage program-counter generator: PC register, fetch handshake toward
// instruction memory, stall/halt control and redirect application.
module pc_fetch_gen
  import pc_fetch_pkg::*;
#(
  parameter int unsigned     XLEN         = DEFAULT_XLEN,
  parameter logic [XLEN-1:0] RESET_VECTOR = XLEN'(DEFAULT_RESET_VECTOR),
  parameter int unsigned     INCR         = DEFAULT_INCR,
  parameter int unsigned     ALIGN_BITS   = DEFAULT_ALIGN_BITS
) (
  input  logic            clk,
  input  logic            reset,
  input  logic            stall,
  input  logic            halt,
  input  logic            resume,
  input  logic            br_valid,
  input  logic [XLEN-1:0] br_target,
  input  logic            trap_valid,
  input  logic [XLEN-1:0] trap_target,
  output logic            fetch_valid,
  input  logic            fetch_ready,
  output logic [XLEN-1:0] fetch_addr,
  output logic [XLEN-1:0] fetch_pc_q,
  output logic            redirect_taken,
  output logic            misalign_err
);

  state_e          state;
  state_e          state_nx;
  logic [XLEN-1:0] pc;
  logic            out_q;
  logic            accept;
  logic            hold;
  logic            direct;
  logic            capture;
  logic            clear;
  logic            redir;
  logic            misalign;
  logic            eff_valid;
  logic [XLEN-1:0] eff_tgt;

  pc_redirect_arb #(
    .XLEN       (XLEN),
    .ALIGN_BITS (ALIGN_BITS)
  ) u_arb (
    .clk         (clk),
    .reset       (reset),
    .trap_valid  (trap_valid),
    .trap_target (trap_target),
    .br_valid    (br_valid),
    .br_target   (br_target),
    .capture     (capture),
    .clear       (clear),
    .redir       (redir),
    .misalign    (misalign),
    .eff_valid   (eff_valid),
    .eff_tgt     (eff_tgt)
  );

  // Handshake decode; a request once raised is held by out_q until accepted.
  always_comb begin
    fetch_valid = out_q | ((state == RUN) & ~stall);
    fetch_addr  = pc;
    accept      = fetch_valid & fetch_ready;
    hold        = fetch_valid & ~fetch_ready;
    direct      = redir & ~fetch_valid & (state != HALT);
    capture     = hold | (state == HALT);
    clear       = accept | direct;
  end

  // Next-state logic: HALT is entered only once no request is left outstanding.
  always_comb begin
    state_nx = state;
    case (state)
      BOOT:    state_nx = RUN;
      RUN:     if (halt && !hold) state_nx = HALT;
      HALT:    if (resume) state_nx = RUN;
      default: state_nx = BOOT;
    endcase
  end

  // State register.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) state <= BOOT;
    else       state <= state_nx;
  end

  // PC, accepted-PC and status pulse registers.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      pc             <= RESET_VECTOR;
      fetch_pc_q     <= '0;
      out_q          <= 1'b0;
      redirect_taken <= 1'b0;
      misalign_err   <= 1'b0;
    end else begin
      out_q          <= hold;
      redirect_taken <= 1'b0;
      misalign_err   <= misalign;
      if (accept) begin
        fetch_pc_q     <= pc;
        pc             <= eff_valid ? eff_tgt : pc + XLEN'(INCR);
        redirect_taken <= eff_valid;
      end else if (direct) begin
        pc             <= eff_tgt;
        redirect_taken <= 1'b1;
      end
    end
  end

endmodule
